// File: rtl/hazard_sequencer_pkg.sv
// Shared definitions for the hazard sequencer.
//   - FWD_* : EX operand forward-select encodings
//   - shadow_entry_t : destination-register record tracked per EX/MEM/WB stage
//   - REG_ZERO : the hard-wired zero register, which never creates a hazard
//   - STG_* : indices into the shadow pipeline array
package hazard_sequencer_pkg;

    localparam int REG_W_PKG = 5;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    localparam logic [REG_W_PKG-1:0] REG_ZERO = '0;

    localparam int STG_EX  = 0;
    localparam int STG_MEM = 1;
    localparam int STG_WB  = 2;
    localparam int NUM_STG = 3;

    typedef struct packed {
        logic                 v;
        logic                 we;
        logic [REG_W_PKG-1:0] rd;
        logic                 ld;
    } shadow_entry_t;

endpackage

// File: rtl/hazard_sequencer_if.sv
// Bundle between the ID stage and the hazard sequencer.
//   master : ID-side driver of decoded fields and redirect; receives controls
//   slave  : the sequencer; receives decoded fields, drives stall/bubble/flush,
//            forward selects, bypass selects and performance counters
interface hazard_sequencer_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_wr_en;
    logic [REG_W-1:0] id_wr_reg;
    logic             id_load;
    logic             redirect;

    logic             stall;
    logic             bubble;
    logic             flush_ifid;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             byp_a;
    logic             byp_b;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wr_en, id_wr_reg, id_load, redirect,
        input  stall, bubble, flush_ifid, fwd_a, fwd_b,
               byp_a, byp_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wr_en, id_wr_reg, id_load, redirect,
        output stall, bubble, flush_ifid, fwd_a, fwd_b,
               byp_a, byp_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_sequencer_match.sv
// hazard_match: combinational compare of one source register against one
// shadow-pipeline entry.
//   src   : source register index read by the ID instruction
//   entry : shadow entry of one stage (EX, MEM or WB)
//   hit   : entry is a live writer of src (valid, writing, and not $0)
module hazard_match
    import hazard_sequencer_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] src,
    input  shadow_entry_t    entry,
    output logic             hit
);

    // The load flag plays no part in a register match; load-use is decided
    // by the caller for the EX stage only.
    logic unused_ld;
    assign unused_ld = entry.ld;

    assign hit = entry.v && entry.we && (entry.rd != REG_ZERO) && (entry.rd == src);

endmodule

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: pipeline hazard control beside the ID stage.
// Keeps a shadow copy of the destination registers of the instructions in
// EX, MEM and WB and from it derives:
//   stall/bubble/flush_ifid : load-use stall and redirect squash (combinational)
//   fwd_a/fwd_b             : EX operand forward selects (registered with EX)
//   byp_a/byp_b             : register-file write-through for ID reads
//   stall_cnt/flush_cnt     : saturating performance counters
// Ports: clk, rst (async, active high), hs (hazard_sequencer_if.slave).
module hazard_sequencer
    import hazard_sequencer_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    hazard_sequencer_if.slave  hs
);

    shadow_entry_t    stage_reg [NUM_STG];
    shadow_entry_t    ex_next;
    logic [NUM_STG-1:0] hit_a;
    logic [NUM_STG-1:0] hit_b;

    logic             load_use;
    logic             stall;
    logic             bubble;
    logic [1:0]       fwd_a_reg, fwd_b_reg;
    logic [1:0]       fwd_a_next, fwd_b_next;
    logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

    // One rs and one rt comparator per shadow stage.
    generate
        for (genvar gi = 0; gi < NUM_STG; gi++) begin : g_match
            hazard_match #(.REG_W(REG_W)) u_match_a (
                .src   (hs.id_rs),
                .entry (stage_reg[gi]),
                .hit   (hit_a[gi])
            );
            hazard_match #(.REG_W(REG_W)) u_match_b (
                .src   (hs.id_rt),
                .entry (stage_reg[gi]),
                .hit   (hit_b[gi])
            );
        end
    endgenerate

    // A load in EX has no data until MEM completes, so a consumer in ID must
    // wait one cycle; after that the WB forward path supplies the value.
    assign load_use = hs.id_valid && stage_reg[STG_EX].ld &&
                      ((hs.id_use_rs && hit_a[STG_EX]) ||
                       (hs.id_use_rt && hit_b[STG_EX]));

    // A redirect squashes the ID instruction anyway, so it overrides a stall.
    assign stall  = load_use && !hs.redirect;
    assign bubble = stall || hs.redirect;

    always_comb begin
        ex_next    = '0;
        fwd_a_next = FWD_RF;
        fwd_b_next = FWD_RF;
        if (!bubble) begin
            ex_next.v  = hs.id_valid;
            ex_next.we = hs.id_wr_en;
            ex_next.rd = hs.id_wr_reg;
            ex_next.ld = hs.id_load;

            // Youngest producer wins: the current EX entry will be in MEM
            // when this instruction reaches EX, the current MEM entry in WB.
            if (hit_a[STG_EX])
                fwd_a_next = FWD_MEM;
            else if (hit_a[STG_MEM])
                fwd_a_next = FWD_WB;

            if (hit_b[STG_EX])
                fwd_b_next = FWD_MEM;
            else if (hit_b[STG_MEM])
                fwd_b_next = FWD_WB;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_STG; i++)
                stage_reg[i] <= '0;
            fwd_a_reg     <= FWD_RF;
            fwd_b_reg     <= FWD_RF;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            stage_reg[STG_WB]  <= stage_reg[STG_MEM];
            stage_reg[STG_MEM] <= stage_reg[STG_EX];
            stage_reg[STG_EX]  <= ex_next;
            fwd_a_reg          <= fwd_a_next;
            fwd_b_reg          <= fwd_b_next;
            // Counters stick at all-ones instead of wrapping.
            if (stall && (stall_cnt_reg != '1))
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            if (hs.redirect && (flush_cnt_reg != '1))
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
        end
    end

    assign hs.stall      = stall;
    assign hs.bubble     = bubble;
    assign hs.flush_ifid = hs.redirect;
    assign hs.fwd_a      = fwd_a_reg;
    assign hs.fwd_b      = fwd_b_reg;
    assign hs.byp_a      = hs.id_use_rs && hit_a[STG_WB];
    assign hs.byp_b      = hs.id_use_rt && hit_b[STG_WB];
    assign hs.stall_cnt  = stall_cnt_reg;
    assign hs.flush_cnt  = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_sequencer.sv
module tb_hazard_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    hazard_sequencer_if #(.REG_W(5), .CNT_W(16)) hs ();
    hazard_sequencer_if #(.REG_W(5), .CNT_W(4))  hs_s ();

    hazard_sequencer #(.REG_W(5), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .hs  (hs)
    );

    // Narrow-counter instance so saturation is reachable in a short run.
    hazard_sequencer #(.REG_W(5), .CNT_W(4)) dut_small (
        .clk (clk),
        .rst (rst),
        .hs  (hs_s)
    );

    // ---------------------------------------------------------------
    // Reference model: the last three issued slots, youngest first.
    // A slot "writes" a register when it was a real instruction with
    // write enable and a nonzero destination.
    // ---------------------------------------------------------------
    typedef struct {
        bit       w;
        bit [4:0] rd;
        bit       ld;
    } slot_t;

    slot_t hist [3];

    function automatic bit writes(slot_t s, logic [4:0] r);
        return s.w && (s.rd == r);
    endfunction

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic we,
                         input logic [4:0] wr, input logic ld, input logic redir);
        hs.id_valid  = v;
        hs.id_rs     = rs;
        hs.id_rt     = rt;
        hs.id_use_rs = urs;
        hs.id_use_rt = urt;
        hs.id_wr_en  = we;
        hs.id_wr_reg = wr;
        hs.id_load   = ld;
        hs.redirect  = redir;
    endtask

    task automatic drive_small(input logic v, input logic [4:0] rs, input logic we,
                               input logic [4:0] wr, input logic ld, input logic redir);
        hs_s.id_valid  = v;
        hs_s.id_rs     = rs;
        hs_s.id_rt     = 5'd0;
        hs_s.id_use_rs = v;
        hs_s.id_use_rt = 1'b0;
        hs_s.id_wr_en  = we;
        hs_s.id_wr_reg = wr;
        hs_s.id_load   = ld;
        hs_s.redirect  = redir;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        nop();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        drive(1, 2, 3, 1, 1, 1, 4, 1, 0);
        rst = 1'b1;
        #1;
        tests++;
        if ({hs.stall, hs.bubble, hs.flush_ifid, hs.fwd_a, hs.fwd_b, hs.stall_cnt, hs.flush_cnt} !== '0) begin
            failed++;
            $display("FAIL reset_state: stall=%b bubble=%b flush=%b fwd_a=%0d fwd_b=%0d scnt=%0d fcnt=%0d, expected all 0",
                     hs.stall, hs.bubble, hs.flush_ifid, hs.fwd_a, hs.fwd_b, hs.stall_cnt, hs.flush_cnt);
        end
        $display("[TB] reset: outputs stall=%b fwd_a=%0d stall_cnt=%0d", hs.stall, hs.fwd_a, hs.stall_cnt);
        rst = 1'b0;
        nop();
        tick();
    endtask

    task automatic test_load_use();
        apply_reset();
        drive(1, 1, 0, 1, 0, 1, 2, 1, 0);          // lw $2
        tick();
        drive(1, 2, 4, 1, 1, 1, 3, 0, 0);          // add $3,$2,$4
        #1;
        tests++;
        if ({hs.stall, hs.bubble} !== 2'b11) begin
            failed++;
            $display("FAIL load_use_stall: stall,bubble=%b expected 11", {hs.stall, hs.bubble});
        end
        tick();                                    // add held in ID
        tests++;
        if ({hs.stall, hs.bubble} !== 2'b00) begin
            failed++;
            $display("FAIL load_use_one_cycle: stall,bubble=%b expected 00", {hs.stall, hs.bubble});
        end
        tick();                                    // add now in EX
        tests++;
        if (hs.fwd_a !== 2'd2 || hs.fwd_b !== 2'd0) begin
            failed++;
            $display("FAIL load_use_fwd: fwd_a=%0d fwd_b=%0d expected 2 0", hs.fwd_a, hs.fwd_b);
        end
        tests++;
        if (hs.stall_cnt !== 16'd1) begin
            failed++;
            $display("FAIL load_use_cnt: stall_cnt=%0d expected 1", hs.stall_cnt);
        end
        $display("[TB] load_use: fwd_a=%0d stall_cnt=%0d", hs.fwd_a, hs.stall_cnt);
    endtask

    task automatic test_fwd_mem();
        apply_reset();
        drive(1, 1, 1, 1, 1, 1, 5, 0, 0);          // add $5,$1,$1
        tick();
        drive(1, 5, 5, 1, 1, 1, 6, 0, 0);          // sub $6,$5,$5
        #1;
        tests++;
        if (hs.stall !== 1'b0) begin
            failed++;
            $display("FAIL fwd_mem_nostall: stall=%b expected 0", hs.stall);
        end
        tick();
        tests++;
        if (hs.fwd_a !== 2'd1 || hs.fwd_b !== 2'd1) begin
            failed++;
            $display("FAIL fwd_mem: fwd_a=%0d fwd_b=%0d expected 1 1", hs.fwd_a, hs.fwd_b);
        end
        $display("[TB] fwd_mem: fwd_a=%0d fwd_b=%0d", hs.fwd_a, hs.fwd_b);
    endtask

    task automatic test_fwd_wb();
        apply_reset();
        drive(1, 1, 1, 1, 1, 1, 7, 0, 0);          // add $7
        tick();
        nop();
        tick();
        drive(1, 0, 7, 1, 1, 1, 8, 0, 0);          // or $8,$0,$7
        tick();
        tests++;
        if (hs.fwd_a !== 2'd0 || hs.fwd_b !== 2'd2) begin
            failed++;
            $display("FAIL fwd_wb: fwd_a=%0d fwd_b=%0d expected 0 2", hs.fwd_a, hs.fwd_b);
        end
        $display("[TB] fwd_wb: fwd_a=%0d fwd_b=%0d", hs.fwd_a, hs.fwd_b);
    endtask

    task automatic test_bypass();
        apply_reset();
        drive(1, 1, 1, 1, 1, 1, 9, 0, 0);          // writer of $9
        tick();
        nop();
        tick();
        tick();                                    // writer now in WB
        drive(1, 1, 9, 1, 1, 1, 10, 0, 0);
        #1;
        tests++;
        if ({hs.byp_a, hs.byp_b} !== 2'b01) begin
            failed++;
            $display("FAIL bypass: byp_a,byp_b=%b expected 01", {hs.byp_a, hs.byp_b});
        end
        tick();
        tests++;
        if (hs.fwd_b !== 2'd0) begin
            failed++;
            $display("FAIL bypass_fwd: fwd_b=%0d expected 0", hs.fwd_b);
        end
        $display("[TB] bypass: byp_b=%b fwd_b=%0d", hs.byp_b, hs.fwd_b);
    endtask

    task automatic test_zero_reg();
        apply_reset();
        drive(1, 1, 1, 1, 1, 1, 0, 1, 0);          // lw $0
        tick();
        drive(1, 0, 0, 1, 1, 1, 3, 0, 0);          // add $3,$0,$0
        #1;
        tests++;
        if (hs.stall !== 1'b0) begin
            failed++;
            $display("FAIL zero_stall: stall=%b expected 0", hs.stall);
        end
        tick();
        tests++;
        if (hs.fwd_a !== 2'd0 || hs.fwd_b !== 2'd0) begin
            failed++;
            $display("FAIL zero_fwd: fwd_a=%0d fwd_b=%0d expected 0 0", hs.fwd_a, hs.fwd_b);
        end
        $display("[TB] zero_reg: stall=%b fwd_a=%0d", hs.stall, hs.fwd_a);
    endtask

    task automatic test_redirect();
        apply_reset();
        drive(1, 1, 0, 1, 0, 1, 2, 1, 0);          // lw $2
        tick();
        drive(1, 2, 4, 1, 1, 1, 3, 0, 1);          // add $3,$2,$4 with redirect
        #1;
        tests++;
        if ({hs.stall, hs.bubble, hs.flush_ifid} !== 3'b011) begin
            failed++;
            $display("FAIL redirect_ctl: stall,bubble,flush=%b expected 011",
                     {hs.stall, hs.bubble, hs.flush_ifid});
        end
        tick();
        tests++;
        if (hs.flush_cnt !== 16'd1 || hs.stall_cnt !== 16'd0) begin
            failed++;
            $display("FAIL redirect_cnt: flush_cnt=%0d stall_cnt=%0d expected 1 0", hs.flush_cnt, hs.stall_cnt);
        end
        // The squashed add ($3) must not be visible as an EX producer.
        drive(1, 3, 3, 1, 1, 1, 6, 0, 0);
        tick();
        tests++;
        if (hs.fwd_a !== 2'd0 || hs.fwd_b !== 2'd0) begin
            failed++;
            $display("FAIL redirect_squash: fwd_a=%0d fwd_b=%0d expected 0 0", hs.fwd_a, hs.fwd_b);
        end
        $display("[TB] redirect: flush_cnt=%0d stall_cnt=%0d fwd_a=%0d", hs.flush_cnt, hs.stall_cnt, hs.fwd_a);
    endtask

    task automatic test_reset_midstall();
        apply_reset();
        drive(1, 1, 0, 1, 0, 1, 2, 1, 0);          // lw $2
        tick();
        drive(1, 2, 4, 1, 1, 1, 3, 0, 0);          // add $3,$2 : stalls once
        tick();
        tick();                                    // add in EX, fwd_a = 2
        drive(1, 3, 0, 1, 0, 1, 5, 1, 0);          // lw $5,($3)
        tick();                                    // fwd_a = 1
        drive(1, 5, 0, 1, 0, 1, 6, 0, 0);          // consumer of $5 : stall
        #1;
        tests++;
        if (hs.stall !== 1'b1 || hs.fwd_a !== 2'd1) begin
            failed++;
            $display("FAIL midstall_setup: stall=%b fwd_a=%0d expected 1 1", hs.stall, hs.fwd_a);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({hs.stall, hs.fwd_a, hs.fwd_b, hs.stall_cnt, hs.flush_cnt} !== '0) begin
            failed++;
            $display("FAIL midstall_reset: stall=%b fwd_a=%0d fwd_b=%0d scnt=%0d fcnt=%0d expected all 0",
                     hs.stall, hs.fwd_a, hs.fwd_b, hs.stall_cnt, hs.flush_cnt);
        end
        #1;
        rst = 1'b0;
        $display("[TB] reset_midstall: stall=%b stall_cnt=%0d", hs.stall, hs.stall_cnt);
        nop();
        tick();
    endtask

    task automatic test_saturation();
        apply_reset();
        // lw $2,($2) repeated: it stalls on itself every other cycle.
        drive_small(1, 2, 1, 2, 1, 0);
        repeat (20) tick();
        tests++;
        if (hs_s.stall_cnt !== 4'd10) begin
            failed++;
            $display("FAIL sat_count: stall_cnt=%0d expected 10", hs_s.stall_cnt);
        end
        repeat (20) tick();
        tests++;
        if (hs_s.stall_cnt !== 4'hF) begin
            failed++;
            $display("FAIL sat_stall: stall_cnt=%0d expected 15", hs_s.stall_cnt);
        end
        drive_small(0, 0, 0, 0, 0, 1);
        repeat (20) tick();
        tests++;
        if (hs_s.flush_cnt !== 4'hF || hs_s.stall_cnt !== 4'hF) begin
            failed++;
            $display("FAIL sat_flush: flush_cnt=%0d stall_cnt=%0d expected 15 15", hs_s.flush_cnt, hs_s.stall_cnt);
        end
        $display("[TB] saturation: stall_cnt=%0d flush_cnt=%0d", hs_s.stall_cnt, hs_s.flush_cnt);
        drive_small(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [4:0] rs, rt, wr;
        logic       v, urs, urt, we, ld, redir;
        bit         lu, e_stall, e_bubble, e_byp_a, e_byp_b;
        int         e_fa, e_fb, e_scnt, e_fcnt;
        slot_t      s_new;
        apply_reset();
        for (int k = 0; k < 3; k++) hist[k] = '{w: 0, rd: 0, ld: 0};
        e_scnt = 0;
        e_fcnt = 0;
        for (int n = 0; n < 400; n++) begin
            v     = ($urandom_range(0, 99) < 85);
            rs    = 5'($urandom_range(0, 3));
            rt    = 5'($urandom_range(0, 3));
            wr    = 5'($urandom_range(0, 3));
            urs   = 1'($urandom_range(0, 1));
            urt   = 1'($urandom_range(0, 1));
            we    = ($urandom_range(0, 99) < 80);
            ld    = ($urandom_range(0, 99) < 35);
            redir = ($urandom_range(0, 99) < 10);
            drive(v, rs, rt, urs, urt, we, wr, ld, redir);
            #1;

            // Distance-based view: slot 0 issued one cycle ago, slot 2 three.
            lu       = v && hist[0].ld && ((urs && writes(hist[0], rs)) || (urt && writes(hist[0], rt)));
            e_stall  = lu && !redir;
            e_bubble = e_stall || redir;
            e_byp_a  = urs && writes(hist[2], rs);
            e_byp_b  = urt && writes(hist[2], rt);
            tests++;
            if ({hs.stall, hs.bubble, hs.flush_ifid, hs.byp_a, hs.byp_b} !==
                {e_stall, e_bubble, redir, e_byp_a, e_byp_b}) begin
                failed++;
                $display("FAIL rand_comb[%0d]: stall,bubble,flush,byp_a,byp_b=%b expected %b",
                         n, {hs.stall, hs.bubble, hs.flush_ifid, hs.byp_a, hs.byp_b},
                         {e_stall, e_bubble, redir, e_byp_a, e_byp_b});
            end

            e_fa = 0;
            e_fb = 0;
            if (!e_bubble) begin
                e_fa = writes(hist[0], rs) ? 1 : (writes(hist[1], rs) ? 2 : 0);
                e_fb = writes(hist[0], rt) ? 1 : (writes(hist[1], rt) ? 2 : 0);
            end
            if (e_stall && e_scnt < 65535) e_scnt++;
            if (redir && e_fcnt < 65535) e_fcnt++;
            s_new = '{w: 0, rd: 0, ld: 0};
            if (!e_bubble && v) s_new = '{w: we && (wr != 0), rd: wr, ld: ld};

            tick();
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = s_new;
            tests++;
            if (hs.fwd_a !== 2'(e_fa) || hs.fwd_b !== 2'(e_fb) ||
                hs.stall_cnt !== 16'(e_scnt) || hs.flush_cnt !== 16'(e_fcnt)) begin
                failed++;
                $display("FAIL rand_seq[%0d]: fwd_a=%0d fwd_b=%0d scnt=%0d fcnt=%0d expected %0d %0d %0d %0d",
                         n, hs.fwd_a, hs.fwd_b, hs.stall_cnt, hs.flush_cnt, e_fa, e_fb, e_scnt, e_fcnt);
            end
        end
        $display("[TB] random: stall_cnt=%0d flush_cnt=%0d expected %0d %0d",
                 hs.stall_cnt, hs.flush_cnt, e_scnt, e_fcnt);
        nop();
    endtask

    initial begin
        nop();
        drive_small(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #12;
        rst = 1'b0;
        tick();
        test_reset();
        test_load_use();
        test_fwd_mem();
        test_fwd_wb();
        test_bypass();
        test_zero_reg();
        test_redirect();
        test_reset_midstall();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
